// File: rtl/imul_arb_pkg.sv
// ============================================================================
//  Module      : imul_arb_pkg
//  Description : Shared types and constants for the multiplier-sharing
//                arbiter: control FSM state encoding, requester limits and
//                an index-width helper that stays legal for NREQ=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imul_arb_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_ISSUE = 2'd1,
    STATE_WAIT  = 2'd2,
    STATE_DRAIN = 2'd3
  } state_t;

  localparam int MAX_NREQ = 8;

  // Width of a requester index; never zero so NREQ=1 still gets a 1-bit bus.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imul_rr_picker.sv
// ============================================================================
//  Module      : imul_rr_picker
//  Description : Combinational round-robin select. Returns the first asserted
//                request found when scanning upward from prio_ptr_i (with
//                wrap-around), plus a flag saying whether any request is set.
//  Ports       : req_val_i   [NREQ]   per-requester valid
//                prio_ptr_i  [IDX_W]  index with the highest priority
//                grant_o     [IDX_W]  selected requester index
//                any_val_o   [1]      at least one requester valid
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imul_rr_picker
  import imul_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_val_i,
  input  logic [IDX_W-1:0] prio_ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_val_o
);

  int              idx;
  logic [NREQ-1:0] shifted;

  // Scan from the lowest priority offset to the highest so the closest
  // valid requester to prio_ptr_i is the last (winning) assignment.
  always_comb begin
    grant_o   = '0;
    any_val_o = 1'b0;
    idx       = 0;
    shifted   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(prio_ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      shifted = req_val_i >> idx;
      if (shifted[0]) begin
        grant_o   = IDX_W'(idx);
        any_val_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imul_share_arbiter.sv
// ============================================================================
//  Module      : imul_share_arbiter
//  Description : Shares one variable-latency iterative multiplier among NREQ
//                val/rdy requesters. Round-robin grant, one operation in
//                flight, result routed back to the issuing requester.
//  Ports       : clk, reset (async, active-low)
//                req_val/req_rdy/req_msg     requester request side
//                resp_val/resp_rdy/resp_msg  requester response side
//                mul_req_*/mul_resp_*        single multiplier core
//                owner                       current/last granted index
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imul_share_arbiter
  import imul_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_val,
  output logic [NREQ-1:0]             req_rdy,
  input  logic [NREQ*2*NBITS-1:0]     req_msg,
  output logic [NREQ-1:0]             resp_val,
  input  logic [NREQ-1:0]             resp_rdy,
  output logic [NREQ*NBITS-1:0]       resp_msg,
  output logic                        mul_req_val,
  input  logic                        mul_req_rdy,
  output logic [2*NBITS-1:0]          mul_req_msg,
  input  logic                        mul_resp_val,
  output logic                        mul_resp_rdy,
  input  logic [NBITS-1:0]            mul_resp_msg,
  output logic [idx_width(NREQ)-1:0]  owner
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int OPW   = 2 * NBITS;

  state_t             state_q;
  logic [OPW-1:0]     op_q;
  logic [NBITS-1:0]   res_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   prio_ptr_q;
  logic [IDX_W-1:0]   prio_ptr_d;
  logic [IDX_W-1:0]   grant;
  logic               any_val;
  logic [OPW-1:0]     req_slice;

  imul_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_val_i  (req_val),
    .prio_ptr_i (prio_ptr_q),
    .grant_o    (grant),
    .any_val_o  (any_val)
  );

  assign req_slice = req_msg[int'(grant)*OPW +: OPW];

  // Priority moves to the requester after the one just served.
  always_comb begin
    prio_ptr_d = owner_q + 1'b1;
    if (int'(owner_q) == NREQ - 1) prio_ptr_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= STATE_IDLE;
      op_q       <= '0;
      res_q      <= '0;
      owner_q    <= '0;
      prio_ptr_q <= '0;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          // req_rdy is raised exactly for the picked requester, so any_val
          // already implies the handshake on the grant.
          if (any_val) begin
            op_q    <= req_slice;
            owner_q <= grant;
            state_q <= STATE_ISSUE;
          end
        end
        STATE_ISSUE: begin
          if (mul_req_rdy) state_q <= STATE_WAIT;
        end
        STATE_WAIT: begin
          if (mul_resp_val) begin
            res_q   <= mul_resp_msg;
            state_q <= STATE_DRAIN;
          end
        end
        STATE_DRAIN: begin
          if (resp_rdy[owner_q]) begin
            prio_ptr_q <= prio_ptr_d;
            state_q    <= STATE_IDLE;
          end
        end
        default: state_q <= STATE_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    req_rdy  = '0;
    resp_val = '0;
    if (state_q == STATE_IDLE && any_val) req_rdy[grant] = 1'b1;
    if (state_q == STATE_DRAIN)           resp_val[owner_q] = 1'b1;
  end

  assign mul_req_val  = (state_q == STATE_ISSUE);
  assign mul_req_msg  = op_q;
  assign mul_resp_rdy = (state_q == STATE_WAIT);
  assign owner        = owner_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_resp
    assign resp_msg[i*NBITS +: NBITS] =
      (state_q == STATE_DRAIN && owner_q == IDX_W'(i)) ? res_q : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_imul_share_arbiter.sv
// ============================================================================
//  Module      : tb_imul_share_arbiter
//  Description : Self-checking bench for imul_share_arbiter with a
//                behavioural multiplier of programmable latency and a
//                transaction-level round-robin/product reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imul_share_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_val;
  logic [3:0]    req_rdy;
  logic [255:0]  req_msg;
  logic [3:0]    resp_val;
  logic [3:0]    resp_rdy;
  logic [127:0]  resp_msg;
  logic          mul_req_val;
  logic          mul_req_rdy;
  logic [63:0]   mul_req_msg;
  logic          mul_resp_val;
  logic          mul_resp_rdy;
  logic [31:0]   mul_resp_msg;
  logic [1:0]    owner;

  // Multiplier model controls
  logic          m_busy, m_val, m_rdy_en, m_spur;
  logic [31:0]   m_res;
  int            m_cnt, m_lat;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imul_share_arbiter #(.NREQ(4), .NBITS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_msg      (req_msg),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_msg     (resp_msg),
    .mul_req_val  (mul_req_val),
    .mul_req_rdy  (mul_req_rdy),
    .mul_req_msg  (mul_req_msg),
    .mul_resp_val (mul_resp_val),
    .mul_resp_rdy (mul_resp_rdy),
    .mul_resp_msg (mul_resp_msg),
    .owner        (owner)
  );

  // Behavioural multiplier: result valid m_lat edges after the accept edge.
  assign mul_req_rdy  = m_rdy_en & ~m_busy;
  assign mul_resp_val = m_val | m_spur;
  assign mul_resp_msg = m_spur ? 32'hDEAD_BEEF : m_res;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_val  <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (!m_busy) begin
      if (mul_req_val && mul_req_rdy) begin
        m_busy <= 1'b1;
        m_res  <= mul_req_msg[63:32] * mul_req_msg[31:0];
        m_cnt  <= m_lat;
      end
    end else if (!m_val) begin
      if (m_cnt <= 1) m_val <= 1'b1;
      else            m_cnt <= m_cnt - 1;
    end else if (mul_resp_rdy) begin
      m_val  <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_msg[i*64 +: 64] = {a, b};
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (req_rdy != 4'b0) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (resp_val != 4'b0) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit ok;
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    bit          busy;
    int          ptr, g, exp_port, done, cyc;
    logic [31:0] exp_val;

    reset    = 1'b0;
    req_val  = '0;
    req_msg  = '0;
    resp_rdy = '0;
    m_rdy_en = 1'b1;
    m_spur   = 1'b0;
    m_lat    = 1;

    // Reset state
    tick(); tick();
    check("rst_outputs", 256'({req_rdy, resp_val, mul_req_val, mul_resp_rdy, owner}), 256'(0));
    check("rst_msgs", 256'({mul_req_msg, resp_msg}), 256'(0));
    reset = 1'b1;
    tick();

    // 1: single requester 2, 3*5, M=1, response at T+4
    req_val = 4'b0100;
    set_op(2, 32'd3, 32'd5);
    #1;
    check("t1_grant", 256'(req_rdy), 256'(4'b0100));
    tick();
    req_val = 4'b0;
    check("t1_issue", 256'({mul_req_val, mul_req_msg}), 256'({1'b1, 32'd3, 32'd5}));
    tick(); tick();
    check("t1_no_early_resp", 256'(resp_val), 256'(0));
    tick();
    check("t1_resp_val", 256'(resp_val), 256'(4'b0100));
    check("t1_resp_msg", 256'(resp_msg), 256'(128'h0000000F) << 64);
    resp_rdy = 4'b0100;
    tick();
    check("t1_done", 256'(resp_val), 256'(0));
    resp_rdy = 4'b0;

    // 2: all requesters valid, rotation 0,1,2,3,0
    pulse_reset();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd2);
    req_val  = 4'hF;
    resp_rdy = 4'hF;
    #1;
    for (int e = 0; e < 5; e++) begin
      g = e % 4;
      wait_rdy(ok);
      check("t2_rdy_timeout", 256'(ok), 256'(1));
      check("t2_grant", 256'(req_rdy), 256'(4'b0001 << g));
      tick();
      wait_resp(ok);
      check("t2_resp_timeout", 256'(ok), 256'(1));
      check("t2_resp_val", 256'(resp_val), 256'(4'b0001 << g));
      check("t2_resp_msg", 256'(resp_msg), 256'(128'(2 * (g + 1))) << (32 * g));
      tick();
    end
    req_val  = 4'b0;
    resp_rdy = 4'b0;
    tick();

    // 3: resp_rdy[1] low 10 cycles in DRAIN (ptr now 1)
    m_lat   = 2;
    req_val = 4'b0010;
    set_op(1, 32'd6, 32'd7);
    set_op(0, 32'd1, 32'd1);
    set_op(2, 32'd2, 32'd2);
    set_op(3, 32'd3, 32'd3);
    #1;
    check("t3_grant", 256'(req_rdy), 256'(4'b0010));
    tick();
    req_val = 4'b0;
    wait_resp(ok);
    check("t3_resp_timeout", 256'(ok), 256'(1));
    req_val = 4'b1101;
    for (int n = 0; n < 10; n++) begin
      #1;
      check("t3_stall_val", 256'(resp_val), 256'(4'b0010));
      check("t3_stall_msg", 256'(resp_msg), 256'(128'd42) << 32);
      check("t3_stall_rdy", 256'(req_rdy), 256'(0));
      tick();
    end
    resp_rdy = 4'b0010;
    tick();
    check("t3_released", 256'(resp_val), 256'(0));
    check("t3_next_grant", 256'(req_rdy), 256'(4'b0100));
    req_val  = 4'b0;
    resp_rdy = 4'b0;
    tick();

    // 4: mul_req_rdy low 5 cycles in ISSUE, 0xFFFFFFFF squared
    m_rdy_en = 1'b0;
    m_lat    = 1;
    req_val  = 4'b0010;
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    check("t4_grant", 256'(req_rdy), 256'(4'b0010));
    tick();
    req_val = 4'b0;
    for (int n = 0; n < 5; n++) begin
      check("t4_hold", 256'({mul_req_val, mul_req_msg}), 256'({1'b1, 64'hFFFF_FFFF_FFFF_FFFF}));
      tick();
    end
    m_rdy_en = 1'b1;
    resp_rdy = 4'hF;
    wait_resp(ok);
    check("t4_resp_timeout", 256'(ok), 256'(1));
    check("t4_resp", 256'({resp_val, resp_msg}), 256'({4'b0010, 128'h1 << 32}));
    tick();
    resp_rdy = 4'b0;

    // 5: reset during WAIT, spurious mul_resp_val afterwards (ptr now 2)
    m_lat   = 20;
    req_val = 4'b0100;
    set_op(2, 32'd5, 32'd9);
    #1;
    check("t5_grant", 256'(req_rdy), 256'(4'b0100));
    tick();
    req_val = 4'b0;
    tick(); tick();
    check("t5_in_wait", 256'({mul_resp_rdy, owner}), 256'({1'b1, 2'd2}));
    reset = 1'b0;
    #1;
    check("t5_async_clear", 256'({req_rdy, resp_val, mul_req_val, mul_resp_rdy, owner}), 256'(0));
    check("t5_async_msgs", 256'({mul_req_msg, resp_msg}), 256'(0));
    tick();
    m_spur = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      check("t5_spurious", 256'({resp_val, mul_resp_rdy, mul_req_val}), 256'(0));
      tick();
    end
    m_spur  = 1'b0;
    req_val = 4'hF;
    #1;
    check("t5_ptr_zero", 256'(req_rdy), 256'(4'b0001));
    req_val = 4'b0;
    tick();

    // 6: random traffic against a transaction-level model
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      ra[i] = rand_opnd();
      rb[i] = rand_opnd();
    end
    busy = 1'b0; ptr = 0; done = 0; cyc = 0;
    exp_port = 0; exp_val = '0;
    while (done < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        req_val[i] = ($urandom_range(0, 1) == 1);
        set_op(i, ra[i], rb[i]);
      end
      resp_rdy = 4'($urandom);
      m_rdy_en = ($urandom_range(0, 3) != 0);
      m_lat    = $urandom_range(1, 4);
      #1;
      if (busy) begin
        check("r_busy_rdy", 256'(req_rdy), 256'(0));
        if (resp_val != 4'b0) begin
          check("r_resp_port", 256'(resp_val), 256'(4'b0001 << exp_port));
          check("r_resp_msg", 256'(resp_msg), 256'(128'(exp_val)) << (32 * exp_port));
          if (resp_rdy[exp_port]) begin
            busy = 1'b0;
            done++;
          end
        end
      end else begin
        check("r_no_resp", 256'(resp_val), 256'(0));
        if (req_val != 4'b0) begin
          g = 0;
          for (int k = 0; k < 4; k++) begin
            if (req_val[(ptr + k) % 4]) begin
              g = (ptr + k) % 4;
              break;
            end
          end
          check("r_grant", 256'(req_rdy), 256'(4'b0001 << g));
          busy     = 1'b1;
          exp_port = g;
          exp_val  = prod(ra[g], rb[g]);
          ptr      = (g + 1) % 4;
          ra[g]    = rand_opnd();
          rb[g]    = rand_opnd();
        end else begin
          check("r_idle_rdy", 256'(req_rdy), 256'(0));
        end
      end
    end
    check("r_ops_done", 256'(done), 256'(1000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
